// File: rtl/urv_mem_arb.sv
// urv_mem_arb: 2:1 memory request arbiter (fetch m0, LSU m1) with in-order response routing.
// Define URV_MEM_ARB_FIXED_PRIO_EN for fixed m1-over-m0 priority instead of round-robin.
package urv_typedef;
  typedef enum logic {MEM_READ = 1'b0, MEM_WRITE = 1'b1} mem_op_t;

  typedef struct packed {
    mem_op_t     req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] resp_rdata;
    logic        resp_err;
  } mem_resp_t;
endpackage

module urv_mem_arb
  import urv_typedef::*;
#(
  parameter int unsigned OST_DEPTH = 4,
  parameter int unsigned OST_CNT_W = $clog2(OST_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_req_valid,
  output logic                 m0_req_ready,
  input  mem_req_t             m0_req,
  output logic                 m0_resp_valid,
  input  logic                 m0_resp_ready,
  output mem_resp_t            m0_resp,
  input  logic                 m1_req_valid,
  output logic                 m1_req_ready,
  input  mem_req_t             m1_req,
  output logic                 m1_resp_valid,
  input  logic                 m1_resp_ready,
  output mem_resp_t            m1_resp,
  output logic                 s_req_valid,
  input  logic                 s_req_ready,
  output mem_req_t             s_req,
  input  logic                 s_resp_valid,
  output logic                 s_resp_ready,
  input  mem_resp_t            s_resp,
  output logic [OST_CNT_W-1:0] ost_cnt,
  output logic                 err_unexp_resp
);

  localparam int unsigned PTR_W = $clog2(OST_DEPTH);

  typedef enum logic {IDLE, LOCKED} arb_state_t;

  arb_state_t           state;
  logic                 lock_id;
  logic                 grant;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 head_id;
  logic [OST_DEPTH-1:0] id_fifo;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;

`ifdef URV_MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = m1_req_valid;
    if (state == LOCKED) grant = lock_id;
  end
`else
  logic rr_ptr;

  always_comb begin
    grant = rr_ptr;
    if (state == LOCKED)                    grant = lock_id;
    else if (m0_req_valid && m1_req_valid) grant = rr_ptr;
    else if (m1_req_valid)                 grant = 1'b1;
    else if (m0_req_valid)                 grant = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rr_ptr <= 1'b0;
    else if (push) rr_ptr <= ~grant;
  end
`endif

  assign full  = (ost_cnt == OST_CNT_W'(OST_DEPTH));
  assign empty = (ost_cnt == '0);

  // Full blocks the push even if a pop frees a slot this cycle.
  always_comb begin
    s_req        = grant ? m1_req : m0_req;
    s_req_valid  = (grant ? m1_req_valid : m0_req_valid) && !full;
    m0_req_ready = !grant && s_req_ready && !full;
    m1_req_ready =  grant && s_req_ready && !full;
    push         = s_req_valid && s_req_ready;
  end

  assign head_id = id_fifo[rd_ptr];

  // An empty FIFO swallows any response and flags it as unexpected.
  always_comb begin
    m0_resp        = s_resp;
    m1_resp        = s_resp;
    m0_resp_valid  = s_resp_valid && !empty && !head_id;
    m1_resp_valid  = s_resp_valid && !empty &&  head_id;
    s_resp_ready   = empty || (head_id ? m1_resp_ready : m0_resp_ready);
    pop            = s_resp_valid && s_resp_ready && !empty;
    err_unexp_resp = s_resp_valid && empty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lock_id <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_req_valid && !s_req_ready) begin
            state   <= LOCKED;
            lock_id <= grant;
          end
        end
        LOCKED: begin
          if (push) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_fifo <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ost_cnt <= '0;
    end else begin
      if (push) begin
        id_fifo[wr_ptr] <= grant;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   ost_cnt <= ost_cnt + 1'b1;
        2'b01:   ost_cnt <= ost_cnt - 1'b1;
        default: ost_cnt <= ost_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_urv_mem_arb.sv
// Bench for urv_mem_arb: directed cycle table for the corner cases, then randomized
// traffic checked against a queue-based reference of the arbitration and routing rules.
module tb_urv_mem_arb;
  import urv_typedef::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam longint      X     = -1;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req_valid, m0_req_ready, m0_resp_valid, m0_resp_ready;
  logic          m1_req_valid, m1_req_ready, m1_resp_valid, m1_resp_ready;
  mem_req_t      m0_req, m1_req, s_req;
  mem_resp_t     m0_resp, m1_resp, s_resp;
  logic          s_req_valid, s_req_ready, s_resp_valid, s_resp_ready;
  logic [CW-1:0] ost_cnt;
  logic          err_unexp_resp;

  urv_mem_arb #(.OST_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req(m0_req),
    .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready), .m0_resp(m0_resp),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req(m1_req),
    .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready), .m1_resp(m1_resp),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req(s_req),
    .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_resp(s_resp),
    .ost_cnt(ost_cnt), .err_unexp_resp(err_unexp_resp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_opt(input string name, input logic [127:0] act, input longint exp);
    if (exp != X) check(name, act, 128'(exp));
  endtask

  // One row per clock cycle; expected fields of X are not checked.
  typedef struct {
    longint rst, m0v, m1v, m1w, srdy, rspv, m0rr, m1rr, a0, a1, rdata;
    longint e_sv, e_sa, e_sw, e_r0, e_r1, e_v0, e_v1, e_rd, e_srr, e_err, e_cnt;
  } vec_t;

  vec_t vec[$];

  task automatic apply(input vec_t v);
    rst           = (v.rst != 0);
    m0_req_valid  = (v.m0v != 0);
    m1_req_valid  = (v.m1v != 0);
    m0_req        = '{req_op: MEM_READ, req_addr: 32'(v.a0), req_wdata: '0, req_be: 4'hF};
    m1_req        = '{req_op: (v.m1w != 0) ? MEM_WRITE : MEM_READ, req_addr: 32'(v.a1),
                      req_wdata: 32'h1234_5678, req_be: 4'hF};
    s_req_ready   = (v.srdy != 0);
    s_resp_valid  = (v.rspv != 0);
    s_resp        = '{resp_rdata: 32'(v.rdata), resp_err: 1'b0};
    m0_resp_ready = (v.m0rr != 0);
    m1_resp_ready = (v.m1rr != 0);
  endtask

  function automatic mem_req_t rand_req();
    mem_req_t r;
    r.req_op    = mem_op_t'($urandom_range(0, 1));
    r.req_addr  = $urandom;
    r.req_wdata = $urandom;
    r.req_be    = 4'($urandom);
    return r;
  endfunction

  mem_req_t m_req [2];
  logic     m_val [2];
  logic     m_rr  [2];
  int       ids[$];
  int       prefer, lock_m, eg, h;
  logic     full, exp_sv, push, pop;

  initial begin
    rst = 1'b1;
    m0_req_valid = 0; m1_req_valid = 0; m0_resp_ready = 0; m1_resp_ready = 0;
    m0_req = '0; m1_req = '0; s_req_ready = 0; s_resp_valid = 0; s_resp = '0;

    //               rst m0v m1v m1w srdy rspv m0rr m1rr a0 a1 rdata | sv sa sw r0 r1 v0 v1 rd srr err cnt
    vec.push_back('{1,0,0,0,0,0,0,0, 0,0,0,              0,X,X,        0,0, 0,0,X,            X,0,0});
    vec.push_back('{0,1,0,0,1,0,0,0, 'h100,0,0,          1,'h100,0,    1,X, 0,0,X,            X,0,0});
    vec.push_back('{0,0,0,0,0,1,1,1, 0,0,'hDEADBEEF,     0,X,X,        0,0, 1,0,'hDEADBEEF,   1,0,1});
    vec.push_back('{0,0,0,0,0,0,0,0, 0,0,0,              0,X,X,        0,0, 0,0,X,            X,0,0});
    vec.push_back('{1,0,0,0,0,0,0,0, 0,0,0,              0,X,X,        0,0, 0,0,X,            X,0,0});
    vec.push_back('{0,1,1,0,1,0,0,0, 'h10,'h20,0,        1,'h10,0,     1,0, 0,0,X,            X,0,0});
    vec.push_back('{0,1,1,0,1,0,0,0, 'h10,'h20,0,        1,'h20,0,     0,1, 0,0,X,            X,0,1});
    vec.push_back('{0,1,1,0,1,0,0,0, 'h10,'h20,0,        1,'h10,0,     1,0, 0,0,X,            X,0,2});
    vec.push_back('{0,1,1,0,1,0,0,0, 'h10,'h20,0,        1,'h20,0,     0,1, 0,0,X,            X,0,3});
    vec.push_back('{0,1,1,0,1,1,1,1, 'h10,'h20,'h1,      0,X,X,        0,0, 1,0,'h1,          1,0,4});
    vec.push_back('{0,1,1,0,1,0,0,0, 'h10,'h20,0,        1,'h10,0,     1,0, 0,0,X,            X,0,3});
    vec.push_back('{0,0,0,0,0,1,1,1, 0,0,'h2,            0,X,X,        0,0, 0,1,'h2,          1,0,4});
    vec.push_back('{0,0,0,0,0,1,1,1, 0,0,'h3,            0,X,X,        0,0, 1,0,'h3,          1,0,3});
    vec.push_back('{0,0,0,0,0,1,1,0, 0,0,'h4,            0,X,X,        0,0, 0,1,'h4,          0,0,2});
    vec.push_back('{0,0,0,0,0,1,1,0, 0,0,'h4,            0,X,X,        0,0, 0,1,'h4,          0,0,2});
    vec.push_back('{0,0,0,0,0,1,1,1, 0,0,'h4,            0,X,X,        0,0, 0,1,'h4,          1,0,2});
    vec.push_back('{0,0,0,0,0,1,1,1, 0,0,'h5,            0,X,X,        0,0, 1,0,'h5,          1,0,1});
    vec.push_back('{0,0,0,0,0,1,1,1, 0,0,'h77,           0,X,X,        0,0, 0,0,X,            1,1,0});
    vec.push_back('{0,0,0,0,0,0,0,0, 0,0,0,              0,X,X,        0,0, 0,0,X,            X,0,0});
    vec.push_back('{0,1,1,1,0,0,0,0, 'h300,'h200,0,      1,'h200,1,    0,0, 0,0,X,            X,0,0});
    vec.push_back('{0,1,1,1,0,0,0,0, 'h300,'h200,0,      1,'h200,1,    0,0, 0,0,X,            X,0,0});
    vec.push_back('{0,1,1,1,0,0,0,0, 'h300,'h200,0,      1,'h200,1,    0,0, 0,0,X,            X,0,0});
    vec.push_back('{0,1,1,1,1,0,0,0, 'h300,'h200,0,      1,'h200,1,    0,1, 0,0,X,            X,0,0});
    vec.push_back('{0,1,1,1,1,0,0,0, 'h300,'h200,0,      1,'h300,0,    1,0, 0,0,X,            X,0,1});
    vec.push_back('{0,0,0,0,0,0,0,0, 0,0,0,              0,X,X,        0,0, 0,0,X,            X,0,2});
    vec.push_back('{1,0,0,0,0,0,0,0, 0,0,0,              0,X,X,        0,0, 0,0,X,            X,0,0});
    vec.push_back('{0,0,0,0,0,1,1,1, 0,0,'h99,           0,X,X,        0,0, 0,0,X,            1,1,0});

    for (int i = 0; i < vec.size(); i++) begin
      @(posedge clk); #1;
      apply(vec[i]);
      #2;
      check_opt($sformatf("row%0d s_req_valid", i), s_req_valid, vec[i].e_sv);
      if (vec[i].e_sv == 1) begin
        check_opt($sformatf("row%0d s_req_addr", i), s_req.req_addr, vec[i].e_sa);
        check_opt($sformatf("row%0d s_req_write", i), s_req.req_op == MEM_WRITE, vec[i].e_sw);
      end
      check_opt($sformatf("row%0d m0_req_ready", i), m0_req_ready, vec[i].e_r0);
      check_opt($sformatf("row%0d m1_req_ready", i), m1_req_ready, vec[i].e_r1);
      check_opt($sformatf("row%0d m0_resp_valid", i), m0_resp_valid, vec[i].e_v0);
      check_opt($sformatf("row%0d m1_resp_valid", i), m1_resp_valid, vec[i].e_v1);
      if (vec[i].e_v0 == 1)
        check_opt($sformatf("row%0d m0_rdata", i), m0_resp.resp_rdata, vec[i].e_rd);
      else if (vec[i].e_v1 == 1)
        check_opt($sformatf("row%0d m1_rdata", i), m1_resp.resp_rdata, vec[i].e_rd);
      check_opt($sformatf("row%0d s_resp_ready", i), s_resp_ready, vec[i].e_srr);
      check_opt($sformatf("row%0d err_unexp", i), err_unexp_resp, vec[i].e_err);
      check_opt($sformatf("row%0d ost_cnt", i), ost_cnt, vec[i].e_cnt);
    end

    // Randomized traffic against a reference built from the arbitration rules.
    @(posedge clk); #1;
    rst = 1'b1; m0_req_valid = 0; m1_req_valid = 0; s_resp_valid = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_val[0] = 0; m_val[1] = 0;
    prefer = 0; lock_m = -1;
    ids.delete();

    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int x = 0; x < 2; x++) begin
        if (!m_val[x] && $urandom_range(0, 2) != 0) begin
          m_req[x] = rand_req();
          m_val[x] = 1'b1;
        end
        m_rr[x] = ($urandom_range(0, 3) != 0);
      end
      m0_req_valid  = m_val[0]; m0_req = m_req[0]; m0_resp_ready = m_rr[0];
      m1_req_valid  = m_val[1]; m1_req = m_req[1]; m1_resp_ready = m_rr[1];
      s_req_ready   = ($urandom_range(0, 3) != 0);
      s_resp_valid  = (ids.size() != 0) ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 7) == 0);
      s_resp        = '{resp_rdata: $urandom, resp_err: 1'($urandom_range(0, 1))};
      #2;

      full = (ids.size() == DEPTH);
      if (lock_m >= 0)            eg = lock_m;
      else if (m_val[0] && m_val[1]) eg = prefer;
      else if (m_val[0])          eg = 0;
      else if (m_val[1])          eg = 1;
      else                        eg = -1;
      exp_sv = (eg >= 0) && !full;

      check("rnd ost_cnt", ost_cnt, ids.size());
      check("rnd s_req_valid", s_req_valid, exp_sv);
      if (exp_sv) check("rnd s_req", s_req, m_req[eg]);
      if (m_val[0]) check("rnd m0_req_ready", m0_req_ready, (eg == 0) && s_req_ready && !full);
      if (m_val[1]) check("rnd m1_req_ready", m1_req_ready, (eg == 1) && s_req_ready && !full);

      pop = 1'b0;
      if (ids.size() == 0) begin
        check("rnd err_unexp", err_unexp_resp, s_resp_valid);
        check("rnd m0_resp_valid", m0_resp_valid, 1'b0);
        check("rnd m1_resp_valid", m1_resp_valid, 1'b0);
        if (s_resp_valid) check("rnd s_resp_ready", s_resp_ready, 1'b1);
      end else begin
        h = ids[0];
        check("rnd err_unexp", err_unexp_resp, 1'b0);
        check("rnd m0_resp_valid", m0_resp_valid, s_resp_valid && (h == 0));
        check("rnd m1_resp_valid", m1_resp_valid, s_resp_valid && (h == 1));
        check("rnd s_resp_ready", s_resp_ready, m_rr[h]);
        if (s_resp_valid) check("rnd resp", (h == 0) ? m0_resp : m1_resp, s_resp);
        pop = s_resp_valid && m_rr[h];
      end

      push = exp_sv && s_req_ready;
      if (pop) void'(ids.pop_front());
      if (push) begin
        ids.push_back(eg);
        m_val[eg] = 1'b0;
        prefer    = 1 - eg;
        lock_m    = -1;
      end else if (exp_sv) begin
        lock_m = eg;
      end
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
